// File: rtl/gpio_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sample_bridge
// Purpose  : Bridges the two-channel ADC/DAC front end to a 32-bit PS GPIO
//            pair. Each ADC channel is boxcar-averaged over 2^AVG_LOG2
//            samples. The two averages are packed into GP_OUT behind a
//            valid/ack handshake that flags overruns. DAC codes written via
//            GP_IN are double-buffered and committed either immediately or
//            on the next averaging-frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sample_bridge #(
    parameter int GPIO_WIDTH = 32,
    parameter int ADC_WIDTH  = 12,
    parameter int DAC_WIDTH  = 14,
    parameter int AVG_LOG2   = 2,
    parameter int SIGN_EXT   = 0,
    parameter int SYNC_DAC   = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADC_WIDTH-1:0]  ADC_A,
    input  logic [ADC_WIDTH-1:0]  ADC_B,
    input  logic                  ADC_VALID,
    input  logic [GPIO_WIDTH-1:0] GP_IN,
    input  logic                  GP_IN_WE,
    input  logic                  GP_OUT_ACK,
    input  logic                  OVR_CLR,
    output logic [GPIO_WIDTH-1:0] GP_OUT,
    output logic                  GP_OUT_VALID,
    output logic                  OVERRUN,
    output logic [DAC_WIDTH-1:0]  DAC_A,
    output logic [DAC_WIDTH-1:0]  DAC_B,
    output logic                  DAC_UPDATE
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_HALF  = GPIO_WIDTH / 2;
    localparam int c_ACC_W = ADC_WIDTH + AVG_LOG2;
    // A one-bit counter is kept for pass-through mode; it never leaves 0.
    localparam int c_CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'((1 << AVG_LOG2) - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_ACC_W-1:0]    acc_a_q, acc_a_d;
    logic [c_ACC_W-1:0]    acc_b_q, acc_b_d;
    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0] gp_out_q, gp_out_d;
    logic                  gp_valid_q, gp_valid_d;
    logic                  overrun_q, overrun_d;
    logic [DAC_WIDTH-1:0]  shadow_a_q, shadow_a_d;
    logic [DAC_WIDTH-1:0]  shadow_b_q, shadow_b_d;
    logic                  pending_q, pending_d;
    logic [DAC_WIDTH-1:0]  dac_a_q, dac_a_d;
    logic [DAC_WIDTH-1:0]  dac_b_q, dac_b_d;
    logic                  dac_upd_q, dac_upd_d;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [c_ACC_W-1:0]   w_ext_a, w_ext_b;
    logic [c_ACC_W-1:0]   w_sum_a, w_sum_b;
    logic [ADC_WIDTH-1:0] w_avg_a, w_avg_b;
    logic [c_HALF-1:0]    w_half_a, w_half_b;
    logic                 w_frame_end;
    logic                 w_commit;
    logic                 w_drop;

    // GP_IN bits outside the two DAC fields carry nothing for this block.
    logic                 w_unused_gp_in;
    assign w_unused_gp_in = ^GP_IN;

    assign w_frame_end = ADC_VALID && (cnt_q == c_CNT_MAX);

    // The frame is dropped if the previous one is still unconsumed and
    // the PS is not acknowledging it in this same cycle.
    assign w_drop = w_frame_end && gp_valid_q && !GP_OUT_ACK;

    // Immediate mode commits on the write itself. Deferred mode commits on a
    // frame boundary if a write is pending or arrives right on that edge.
    assign w_commit = (SYNC_DAC != 0) ? (w_frame_end && (pending_q || GP_IN_WE))
                                      : GP_IN_WE;

    // Widen samples into the accumulator domain, then form the running sum.
    always_comb begin
        if (SIGN_EXT != 0) begin
            w_ext_a = c_ACC_W'($signed(ADC_A));
            w_ext_b = c_ACC_W'($signed(ADC_B));
        end else begin
            w_ext_a = c_ACC_W'(ADC_A);
            w_ext_b = c_ACC_W'(ADC_B);
        end
        w_sum_a = acc_a_q + w_ext_a;
        w_sum_b = acc_b_q + w_ext_b;
    end

    // Divide by the frame length (floor) and extend each average to a half-word.
    always_comb begin
        if (SIGN_EXT != 0) begin
            w_avg_a  = ADC_WIDTH'($signed(w_sum_a) >>> AVG_LOG2);
            w_avg_b  = ADC_WIDTH'($signed(w_sum_b) >>> AVG_LOG2);
            w_half_a = c_HALF'($signed(w_avg_a));
            w_half_b = c_HALF'($signed(w_avg_b));
        end else begin
            w_avg_a  = ADC_WIDTH'(w_sum_a >> AVG_LOG2);
            w_avg_b  = ADC_WIDTH'(w_sum_b >> AVG_LOG2);
            w_half_a = c_HALF'(w_avg_a);
            w_half_b = c_HALF'(w_avg_b);
        end
    end

    // Accumulator and sample counter. They advance only on qualified samples.
    always_comb begin
        acc_a_d = acc_a_q;
        acc_b_d = acc_b_q;
        cnt_d   = cnt_q;
        if (ADC_VALID) begin
            if (w_frame_end) begin
                acc_a_d = '0;
                acc_b_d = '0;
                cnt_d   = '0;
            end else begin
                acc_a_d = w_sum_a;
                acc_b_d = w_sum_b;
                cnt_d   = cnt_q + c_CNT_W'(1);
            end
        end
    end

    // Output handshake. A set of OVERRUN takes priority over a clear in the same cycle.
    always_comb begin
        gp_out_d   = gp_out_q;
        gp_valid_d = gp_valid_q;
        overrun_d  = overrun_q;
        if (OVR_CLR) begin
            overrun_d = 1'b0;
        end
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (w_frame_end) begin
            gp_out_d   = {w_half_b, w_half_a};
            gp_valid_d = 1'b1;
        end else if (GP_OUT_ACK && gp_valid_q) begin
            gp_valid_d = 1'b0;
        end
    end

    // DAC shadow register and commit. A write on the commit edge bypasses the shadow.
    always_comb begin
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        pending_d  = pending_q;
        dac_a_d    = dac_a_q;
        dac_b_d    = dac_b_q;
        dac_upd_d  = w_commit;
        if (GP_IN_WE) begin
            shadow_a_d = GP_IN[DAC_WIDTH-1:0];
            shadow_b_d = GP_IN[c_HALF +: DAC_WIDTH];
            pending_d  = 1'b1;
        end
        if (w_commit) begin
            pending_d = 1'b0;
            dac_a_d   = GP_IN_WE ? GP_IN[DAC_WIDTH-1:0]      : shadow_a_q;
            dac_b_d   = GP_IN_WE ? GP_IN[c_HALF +: DAC_WIDTH] : shadow_b_q;
        end
    end

    // State registers. Reset also discards any partially accumulated frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            cnt_q      <= '0;
            gp_out_q   <= '0;
            gp_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            pending_q  <= 1'b0;
            dac_a_q    <= '0;
            dac_b_q    <= '0;
            dac_upd_q  <= 1'b0;
        end else begin
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            cnt_q      <= cnt_d;
            gp_out_q   <= gp_out_d;
            gp_valid_q <= gp_valid_d;
            overrun_q  <= overrun_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            pending_q  <= pending_d;
            dac_a_q    <= dac_a_d;
            dac_b_q    <= dac_b_d;
            dac_upd_q  <= dac_upd_d;
        end
    end

    assign GP_OUT       = gp_out_q;
    assign GP_OUT_VALID = gp_valid_q;
    assign OVERRUN      = overrun_q;
    assign DAC_A        = dac_a_q;
    assign DAC_B        = dac_b_q;
    assign DAC_UPDATE   = dac_upd_q;

endmodule
`default_nettype wire
